// File: rtl/arith_pkg.sv
// Shared constants for the serial arithmetic cells: FSM encodings and default width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic p;

    assign p    = x ^ y;
    assign d    = p ^ bin;
    assign bout = (~x & y) | (~p & bin);
endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
module bit_serial_subtractor
    import arith_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic                  clk,
    input logic                  rst_n,
    bit_serial_subtractor_if.slave bus
);
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic             borrow;
    logic             a_sign;
    logic             b_sign;
    logic             d;
    logic             bout;

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    // DONE spends one cycle publishing the shift-register result, so done
    // lands WIDTH+1 edges after acceptance and busy lags RUN by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            a_sh           <= '0;
            b_sh           <= '0;
            diff_sh        <= '0;
            borrow         <= 1'b0;
            a_sign         <= 1'b0;
            b_sign         <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.busy <= (state == RUN);
            bus.done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_sign <= bus.a[WIDTH-1];
                        b_sign <= bus.b[WIDTH-1];
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= {d, diff_sh[WIDTH-1:1]};
                    borrow  <= bout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    bus.diff       <= diff_sh;
                    bus.borrow_out <= borrow;
                    bus.overflow   <= (a_sign != b_sign) && (diff_sh[WIDTH-1] != a_sign);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed and back-to-back random checks of the bit-serial subtractor.
module tb_bit_serial_subtractor;
    localparam int W = 32;
    localparam int NV = 1003;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    bit_serial_subtractor_if #(.WIDTH(W)) bus ();

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns {overflow, borrow_out, diff}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] w;
        logic       ov;
        w  = {1'b0, x} - {1'b0, y};
        ov = (x[W-1] != y[W-1]) && (w[W-1] != x[W-1]);
        return {ov, w[W], w[W-1:0]};
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input int inject_at, input int reset_at,
                          input logic [W-1:0] xd, input logic xbo, input logic xov);
        int n;
        int busy_n;
        int extra;
        bit seen;
        bit aborted;
        @(negedge clk);
        bus.a = ea;
        bus.b = eb;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0; busy_n = 0; seen = 0; aborted = 0; extra = 0;
        while (!seen && !aborted && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) check({tag, "_busy_and_done"}, 1, 0);
            if (bus.done) seen = 1;
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.a = 1;
                bus.b = 1;
            end
            if (inject_at > 0 && n == inject_at + 1) bus.start = 1'b0;
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                aborted = 1;
            end
        end
        if (aborted) begin
            check({tag, "_rst_busy"}, bus.busy, 0);
            check({tag, "_rst_done"}, bus.done, 0);
            check({tag, "_rst_diff"}, bus.diff, 0);
            check({tag, "_rst_borrow"}, bus.borrow_out, 0);
            check({tag, "_rst_ovf"}, bus.overflow, 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (bus.done) extra++;
            end
            check({tag, "_no_done"}, extra, 0);
        end else begin
            check({tag, "_latency"}, n, 33);
            check({tag, "_busy_cycles"}, busy_n, 32);
            check({tag, "_diff"}, bus.diff, xd);
            check({tag, "_borrow"}, bus.borrow_out, xbo);
            check({tag, "_ovf"}, bus.overflow, xov);
            repeat (40) begin
                @(posedge clk);
                #1;
                if (bus.done) extra++;
            end
            check({tag, "_single_done"}, extra, 0);
            check({tag, "_diff_hold"}, bus.diff, xd);
        end
    endtask

    logic [W-1:0] va [NV];
    logic [W-1:0] vb [NV];

    initial begin
        int n;
        bit seen;
        logic [W+1:0] m;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_diff", bus.diff, 0);
        check("reset_borrow", bus.borrow_out, 0);
        check("reset_ovf", bus.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub5_3",   32'd5,          32'd3,          0, 0,  32'h0000_0002, 1'b0, 1'b0);
        run_op("sub3_5",   32'd3,          32'd5,          0, 0,  32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("min_one",  32'h8000_0000,  32'h0000_0001,  0, 0,  32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("max_neg1", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  0, 0,  32'h8000_0000, 1'b1, 1'b1);
        run_op("ignore",   32'd10,         32'd4,          5, 0,  32'h0000_0006, 1'b0, 1'b0);
        run_op("abort",    32'hFFFF_FFFF,  32'h0,          0, 10, 32'h0,         1'b0, 1'b0);
        run_op("zero",     32'h0,          32'h0,          0, 0,  32'h0,         1'b0, 1'b0);

        va[0] = 32'd5;         vb[0] = 32'd3;
        va[1] = 32'd3;         vb[1] = 32'd5;
        va[2] = 32'h8000_0000; vb[2] = 32'h1;
        for (int i = 3; i < NV; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end

        @(negedge clk);
        bus.a = va[0];
        bus.b = vb[0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = va[1];
        bus.b = vb[1];
        for (int k = 0; k < NV; k++) begin
            n = 0;
            seen = 0;
            while (!seen && n < 60) begin
                @(posedge clk);
                #1;
                n++;
                if (bus.done) seen = 1;
                if (n == 1 && k > 0 && k + 1 < NV) begin
                    bus.a = va[k+1];
                    bus.b = vb[k+1];
                end
            end
            if (k == NV - 1) bus.start = 1'b0;
            m = model(va[k], vb[k]);
            check($sformatf("b2b%0d_interval", k), n, (k == 0) ? 33 : 34);
            check($sformatf("b2b%0d_diff", k), bus.diff, m[W-1:0]);
            check($sformatf("b2b%0d_borrow", k), bus.borrow_out, m[W]);
            check($sformatf("b2b%0d_ovf", k), bus.overflow, m[W+1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
